chan_accum_unit: RTL and testbench

- Parametrised successor to the board-level switch-nibble adder.
- Treats the SW bus as CH unsigned channels of W bits each and reduces them to one OUT_W-bit result shown on LED.
- Runs one channel per clock under an FSM. The reduction is either sum or maximum, and a saturating overflow flag is provided.
- Started by a synchronised, edge-detected press of BTNC. Sits directly under the board top, between the switches/buttons and the LEDs.

---
 rtl/chan_accum_pkg.sv | 16 +
 rtl/btn_edge_sync.sv | 32 +++
 rtl/chan_accum_unit.sv | 123 ++++++++++++
 tb/tb_chan_accum_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/chan_accum_pkg.sv
// chan_accum_pkg
//   Shared types for the channel accumulator.
//   state_t : FSM states (idle, running one channel per clock, done pulse).
//   MODE_*  : reduction select values for the MODE input.
package chan_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_SUM = 1'b0;
   localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync
//   Synchronises a raw asynchronous button and emits a one-cycle pulse on
//   each rising edge. The pulse is registered, so it appears 3 clocks after
//   the button rises. A held button gives exactly one pulse.
//   clk   : system clock
//   rst   : asynchronous active-high clear
//   btn   : raw button input
//   pulse : one-cycle rising-edge pulse
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic sync1, sync2, prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
         pulse <= sync2 & ~prev;
      end
   end

endmodule

// File: rtl/chan_accum_unit.sv
// chan_accum_unit
//   Reduces CH unsigned W-bit channels packed on SW into one OUT_W-bit
//   result, one channel per clock. MODE selects saturating sum or maximum.
//   An operation starts on a debounced-free, synchronised rising edge of BTNC.
//   CLK100MHZ : system clock
//   RST       : asynchronous active-high reset
//   BTNC      : raw start button
//   MODE      : 0 = sum, 1 = max (sampled at start)
//   SW        : channel c = SW[c*W +: W] (sampled at start)
//   LED       : result of the last completed operation
//   BUSY      : operation in progress
//   DONE      : one-cycle pulse when LED updates
//   OVF       : sum saturated in the last completed operation
module chan_accum_unit
   import chan_accum_pkg::*;
#(
   parameter int CH    = 4,
   parameter int W     = 4,
   parameter int OUT_W = 16
) (
   input  logic              CLK100MHZ,
   input  logic              RST,
   input  logic              BTNC,
   input  logic              MODE,
   input  logic [CH*W-1:0]   SW,
   output logic [OUT_W-1:0]  LED,
   output logic              BUSY,
   output logic              DONE,
   output logic              OVF
);

   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [OUT_W:0]  SAT  = {1'b0, {OUT_W{1'b1}}};
   localparam logic [CW-1:0]   LAST = CW'(CH - 1);

   state_t             state, state_nxt;
   logic               start;
   logic [CH*W-1:0]    snap;
   logic               mode_r;
   logic [OUT_W-1:0]   acc, acc_nxt;
   logic [CW-1:0]      idx;
   logic               ovf_r, ovf_nxt;
   logic [W-1:0]       ch_raw;
   logic [OUT_W:0]     ch_ext, sum_t;
   logic               last;

   btn_edge_sync u_start (
      .clk   (CLK100MHZ),
      .rst   (RST),
      .btn   (BTNC),
      .pulse (start)
   );

   // One extra bit on the sum so overflow past 2^OUT_W-1 is visible.
   always_comb begin
      ch_raw  = snap[idx*W +: W];
      ch_ext  = {{(OUT_W+1-W){1'b0}}, ch_raw};
      sum_t   = {1'b0, acc} + ch_ext;
      acc_nxt = acc;
      ovf_nxt = ovf_r;
      if (mode_r == MODE_MAX) begin
         if (ch_ext > {1'b0, acc}) acc_nxt = ch_ext[OUT_W-1:0];
      end else if (sum_t > SAT) begin
         acc_nxt = SAT[OUT_W-1:0];
         ovf_nxt = 1'b1;
      end else begin
         acc_nxt = sum_t[OUT_W-1:0];
      end
   end

   assign last = (idx == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (last)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // LED/OVF load with the final channel's update as the FSM enters DONE,
   // so they change in the same cycle the DONE pulse is visible.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         snap   <= '0;
         mode_r <= MODE_SUM;
         acc    <= '0;
         idx    <= '0;
         ovf_r  <= 1'b0;
         LED    <= '0;
         OVF    <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         state <= state_nxt;
         BUSY  <= (state_nxt != ST_IDLE);
         DONE  <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: if (start) begin
               snap   <= SW;
               mode_r <= MODE;
               acc    <= '0;
               idx    <= '0;
               ovf_r  <= 1'b0;
            end
            ST_RUN: begin
               acc   <= acc_nxt;
               ovf_r <= ovf_nxt;
               idx   <= idx + 1'b1;
               if (last) begin
                  LED <= acc_nxt;
                  OVF <= ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chan_accum_unit.sv
module tb_chan_accum_unit;

   logic        clk = 1'b0;
   logic        RST, BTNC, MODE;
   logic [15:0] SW;

   logic [15:0] la;  logic busy_a, done_a, ovf_a;
   logic [4:0]  lb;  logic busy_b, done_b, ovf_b;
   logic [7:0]  lc;  logic busy_c, done_c, ovf_c;

   int checks = 0;
   int errors = 0;
   int dn_a, dn_b, dn_c, bz_a, first_a, first_c;

   always #5 clk = ~clk;

   chan_accum_unit #(.CH(4), .W(4), .OUT_W(16)) ua (
      .CLK100MHZ(clk), .RST(RST), .BTNC(BTNC), .MODE(MODE), .SW(SW),
      .LED(la), .BUSY(busy_a), .DONE(done_a), .OVF(ovf_a));

   chan_accum_unit #(.CH(4), .W(4), .OUT_W(5)) ub (
      .CLK100MHZ(clk), .RST(RST), .BTNC(BTNC), .MODE(MODE), .SW(SW),
      .LED(lb), .BUSY(busy_b), .DONE(done_b), .OVF(ovf_b));

   chan_accum_unit #(.CH(8), .W(2), .OUT_W(8)) uc (
      .CLK100MHZ(clk), .RST(RST), .BTNC(BTNC), .MODE(MODE), .SW(SW),
      .LED(lc), .BUSY(busy_c), .DONE(done_c), .OVF(ovf_c));

   // Short press, then watch ncyc falling edges. Cycle i is sampled after the
   // i-th rising edge following the press.
   task automatic do_op(input logic [15:0] sw, input logic mode, input int ncyc);
      @(negedge clk);
      SW = sw; MODE = mode; BTNC = 1'b1;
      dn_a = 0; dn_b = 0; dn_c = 0; bz_a = 0; first_a = -1; first_c = -1;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (i == 2) BTNC = 1'b0;
         if (done_a) begin dn_a++; if (first_a < 0) first_a = i; end
         if (done_c) begin dn_c++; if (first_c < 0) first_c = i; end
         if (done_b) dn_b++;
         if (busy_a) bz_a++;
      end
   endtask

   task automatic test_reset;
      RST = 1'b1; BTNC = 1'b0; MODE = 1'b0; SW = 16'h0000;
      repeat (3) @(negedge clk);
      checks++; if (la !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", la); end
      checks++; if ({busy_a, done_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy_a, done_a, ovf_a}); end
      checks++; if ({lb, lc} !== 13'h0) begin errors++; $display("FAIL reset_other got %h exp 0", {lb, lc}); end
      RST = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_sum_basic;
      do_op(16'hFFFF, 1'b0, 16);
      checks++; if (la !== 16'h003C) begin errors++; $display("FAIL sum_ffff got %h exp 003c", la); end
      checks++; if (dn_a !== 1) begin errors++; $display("FAIL sum_done_count got %0d exp 1", dn_a); end
      checks++; if (first_a !== 8) begin errors++; $display("FAIL sum_latency got %0d exp 8", first_a); end
      checks++; if (bz_a !== 5) begin errors++; $display("FAIL sum_busy_cycles got %0d exp 5", bz_a); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL sum_ovf got %b exp 0", ovf_a); end
   endtask

   task automatic test_max_then_sum;
      do_op(16'h3A51, 1'b1, 16);
      checks++; if (la !== 16'h000A) begin errors++; $display("FAIL max_3a51 got %h exp 000a", la); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL max_ovf got %b exp 0", ovf_a); end
      do_op(16'h3A51, 1'b0, 16);
      checks++; if (la !== 16'h0013) begin errors++; $display("FAIL sum_3a51 got %h exp 0013", la); end
   endtask

   task automatic test_saturate;
      do_op(16'hFFFF, 1'b0, 16);
      checks++; if (lb !== 5'h1F) begin errors++; $display("FAIL sat_led got %h exp 1f", lb); end
      checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", ovf_b); end
      repeat (5) @(negedge clk);
      checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf_hold got %b exp 1", ovf_b); end
      do_op(16'h0001, 1'b0, 16);
      checks++; if (lb !== 5'h01) begin errors++; $display("FAIL sat_next_led got %h exp 01", lb); end
      checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL sat_next_ovf got %b exp 0", ovf_b); end
   endtask

   task automatic test_hold_and_busy_press;
      int n;
      @(negedge clk);
      SW = 16'hFFFF; MODE = 1'b0; BTNC = 1'b1; n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 5) SW = 16'h1111;
         if (done_a) n++;
      end
      BTNC = 1'b0;
      checks++; if (n !== 1) begin errors++; $display("FAIL hold_done_count got %0d exp 1", n); end
      checks++; if (la !== 16'h003C) begin errors++; $display("FAIL hold_snapshot got %h exp 003c", la); end
      repeat (4) @(negedge clk);
      // second rising edge lands while BUSY: must be dropped
      SW = 16'h3A51; BTNC = 1'b1; n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) BTNC = 1'b0;
         if (i == 4) BTNC = 1'b1;
         if (i == 6) BTNC = 1'b0;
         if (done_a) n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL busy_press_done_count got %0d exp 1", n); end
      checks++; if (la !== 16'h0013) begin errors++; $display("FAIL busy_press_led got %h exp 0013", la); end
   endtask

   task automatic test_reset_abort;
      int n;
      @(negedge clk);
      SW = 16'hFFFF; MODE = 1'b0; BTNC = 1'b1; n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) BTNC = 1'b0;
         if (i == 5) begin
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b exp 1", busy_a); end
            RST = 1'b1;
            #1;
            checks++; if ({la, busy_a} !== 17'h0) begin errors++; $display("FAIL abort_async got %h/%b exp 0000/0", la, busy_a); end
         end
         if (i == 6) RST = 1'b0;
         if (done_a) n++;
      end
      checks++; if (n !== 0) begin errors++; $display("FAIL abort_done_count got %0d exp 0", n); end
      checks++; if ({la, busy_a, ovf_a} !== 18'h0) begin errors++; $display("FAIL abort_state got %h/%b/%b exp 0000/0/0", la, busy_a, ovf_a); end
      do_op(16'h3A51, 1'b1, 16);
      checks++; if (la !== 16'h000A) begin errors++; $display("FAIL abort_recover got %h exp 000a", la); end
   endtask

   task automatic test_wide;
      do_op(16'hFFFF, 1'b0, 16);
      checks++; if (lc !== 8'h18) begin errors++; $display("FAIL wide_led got %h exp 18", lc); end
      checks++; if (first_c !== 12) begin errors++; $display("FAIL wide_latency got %0d exp 12", first_c); end
      checks++; if (dn_c !== 1) begin errors++; $display("FAIL wide_done_count got %0d exp 1", dn_c); end
      checks++; if (ovf_c !== 1'b0) begin errors++; $display("FAIL wide_ovf got %b exp 0", ovf_c); end
   endtask

   initial begin
      test_reset;
      test_sum_basic;
      test_max_then_sum;
      test_saturate;
      test_hold_and_busy_press;
      test_reset_abort;
      test_wide;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
